decode_inst_queue: RTL and testbench

- Parametrised successor to the single-register decode pipeline stage; sits between fetch and decode/execute.
- Replaces the one-deep fetch→decode pipe register with a DEPTH-entry instruction queue using valid/ready handshake, stall hold, flush, and bubble insertion.
- Extracts register-file read addresses (rs1/rs2) and rd from the head entry, so the register file is read in the same cycle the head is presented.

---
 rtl/decode_inst_queue.sv | 124 ++++++++++++
 tb/tb_decode_inst_queue.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_inst_queue.sv
// Fetch-to-decode instruction queue with valid/ready handshake, stall hold, flush bubble
// and head register-address extraction. Optional same-cycle bypass: DECODE_INST_QUEUE_BYPASS_EN.
module decode_inst_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned BP_WIDTH   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PC_WIDTH-1:0]           in_pc,
  input  logic [INST_WIDTH-1:0]         in_inst,
  input  logic [BP_WIDTH-1:0]           in_bp,
  input  logic                          stall,
  input  logic                          flush,
  output logic                          out_valid,
  output logic [PC_WIDTH-1:0]           out_pc,
  output logic [INST_WIDTH-1:0]         out_inst,
  output logic [BP_WIDTH-1:0]           out_bp,
  output logic [4:0]                    rs1_addr,
  output logic [4:0]                    rs2_addr,
  output logic [4:0]                    rd_addr,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [BP_WIDTH-1:0]   bp;
    logic [INST_WIDTH-1:0] inst;
    logic [PC_WIDTH-1:0]   pc;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  entry_t in_entry_c;
  entry_t head_c;
  logic   empty_c;
  logic   push_c;
  logic   pop_c;
  logic   bypass_c;
  logic   wr_en_c;
  logic   rd_en_c;

  // Handshake, head selection and flush/empty gating of all head-derived outputs
  always_comb begin
    in_entry_c = '{bp: in_bp, inst: in_inst, pc: in_pc};
    empty_c    = (count_q == '0);
    in_ready   = (count_q < CNT_W'(DEPTH));
    push_c     = in_valid & in_ready & ~flush;
`ifdef DECODE_INST_QUEUE_BYPASS_EN
    bypass_c   = push_c & empty_c;
`else
    bypass_c   = 1'b0;
`endif
    out_valid  = ~flush & (~empty_c | bypass_c);
    pop_c      = out_valid & ~stall;
    // A bypassed entry consumed in the same cycle never touches storage
    wr_en_c    = push_c & ~(bypass_c & pop_c);
    rd_en_c    = pop_c & ~empty_c;
    head_c     = bypass_c ? in_entry_c : mem_q[rd_ptr_q];

    out_pc     = '0;
    out_inst   = '0;
    out_bp     = '0;
    rs1_addr   = '0;
    rs2_addr   = '0;
    rd_addr    = '0;
    if (out_valid) begin
      out_pc   = head_c.pc;
      out_inst = head_c.inst;
      out_bp   = head_c.bp;
      rs1_addr = head_c.inst[19:15];
      rs2_addr = head_c.inst[24:20];
      rd_addr  = head_c.inst[11:7];
    end
  end

  // Pointer and occupancy next-state; flush empties the queue at the next edge
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_en_c, rd_en_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by count_q
  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[wr_ptr_q] <= in_entry_c;
  end

  assign count = count_q;

endmodule

// File: tb/tb_decode_inst_queue.sv
// Self-checking bench for decode_inst_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_decode_inst_queue;

  localparam int unsigned DEPTH      = 4;
  localparam int unsigned PC_WIDTH   = 32;
  localparam int unsigned INST_WIDTH = 32;
  localparam int unsigned BP_WIDTH   = 1;
  localparam int unsigned CNT_W      = $clog2(DEPTH+1);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [PC_WIDTH-1:0]   in_pc;
  logic [INST_WIDTH-1:0] in_inst;
  logic [BP_WIDTH-1:0]   in_bp;
  logic                  stall;
  logic                  flush;
  logic                  out_valid;
  logic [PC_WIDTH-1:0]   out_pc;
  logic [INST_WIDTH-1:0] out_inst;
  logic [BP_WIDTH-1:0]   out_bp;
  logic [4:0]            rs1_addr;
  logic [4:0]            rs2_addr;
  logic [4:0]            rd_addr;
  logic [CNT_W-1:0]      count;

  decode_inst_queue #(
    .DEPTH(DEPTH), .PC_WIDTH(PC_WIDTH), .INST_WIDTH(INST_WIDTH), .BP_WIDTH(BP_WIDTH)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_bp(in_bp),
    .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_bp(out_bp),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PC_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0] inst;
    logic [BP_WIDTH-1:0]   bp;
  } ent_t;

  ent_t mq[$];
  bit   model_known = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic                  obs_valid;
  logic                  obs_ready;
  logic [PC_WIDTH-1:0]   obs_pc;
  logic [CNT_W-1:0]      obs_count;
  logic [4:0]            obs_rs1, obs_rs2, obs_rd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare against the model, then advance the model at the edge
  task automatic cycle(input logic r, input logic iv, input logic [PC_WIDTH-1:0] pc,
                       input logic [INST_WIDTH-1:0] inst, input logic [BP_WIDTH-1:0] bp,
                       input logic st, input logic fl);
    int   n;
    bit   e_ready, e_valid, push, pop, byp;
    ent_t h;
    ent_t inc;
    @(negedge clk);
    rst = r; in_valid = iv; in_pc = pc; in_inst = inst; in_bp = bp; stall = st; flush = fl;
    #1;
    inc     = '{pc, inst, bp};
    n       = mq.size();
    e_ready = (n < DEPTH);
    push    = iv && e_ready && !fl;
    byp     = 1'b0;
`ifdef DECODE_INST_QUEUE_BYPASS_EN
    byp     = push && (n == 0);
`endif
    e_valid = !fl && ((n > 0) || byp);
    h       = '{'0, '0, '0};
    if (e_valid) h = (n > 0) ? mq[0] : inc;
    pop     = e_valid && !st;

    obs_valid = out_valid; obs_ready = in_ready; obs_pc = out_pc; obs_count = count;
    obs_rs1 = rs1_addr; obs_rs2 = rs2_addr; obs_rd = rd_addr;

    if (model_known) begin
      check("out_valid", 64'(out_valid), 64'(e_valid));
      check("in_ready",  64'(in_ready),  64'(e_ready));
      check("count",     64'(count),     64'(n));
      check("out_pc",    64'(out_pc),    64'(h.pc));
      check("out_inst",  64'(out_inst),  64'(h.inst));
      check("out_bp",    64'(out_bp),    64'(h.bp));
      check("rs1_addr",  64'(rs1_addr),  64'(h.inst[19:15]));
      check("rs2_addr",  64'(rs2_addr),  64'(h.inst[24:20]));
      check("rd_addr",   64'(rd_addr),   64'(h.inst[11:7]));
    end

    if (r || fl) begin
      mq.delete();
      if (r) model_known = 1'b1;
    end else begin
      if (pop && n > 0) void'(mq.pop_front());
      if (push && !(byp && pop)) mq.push_back(inc);
    end
    @(posedge clk);
  endtask

  task automatic idle(input logic st);
    cycle(1'b0, 1'b0, '0, '0, '0, st, 1'b0);
  endtask

  task automatic push_one(input logic [PC_WIDTH-1:0] pc, input logic st);
    cycle(1'b0, 1'b1, pc, INST_WIDTH'($urandom), BP_WIDTH'($urandom_range(0, 1)), st, 1'b0);
  endtask

  initial begin
    bit accepted;
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; in_bp = '0; stall = 1'b0; flush = 1'b0;

    // Reset state
    cycle(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    idle(1'b0);
    check("rst_valid", 64'(obs_valid), 64'(0));
    check("rst_ready", 64'(obs_ready), 64'(1));
    check("rst_count", 64'(obs_count), 64'(0));

    // Three back-to-back pushes with no stall
    push_one(32'h100, 1'b0);
    push_one(32'h104, 1'b0);
`ifndef DECODE_INST_QUEUE_BYPASS_EN
    check("lat_first_pc", 64'(obs_pc), 64'h100);
`endif
    push_one(32'h108, 1'b0);
    repeat (4) idle(1'b0);
    check("drain_count", 64'(obs_count), 64'(0));

    // Fill under stall, hold a fifth entry, then release
    for (int i = 0; i < 4; i++) push_one(PC_WIDTH'(32'h180 + 4 * i), 1'b1);
    cycle(1'b0, 1'b1, 32'h200, 32'h0, 1'b0, 1'b1, 1'b0);
    check("full_ready", 64'(obs_ready), 64'(0));
    check("full_count", 64'(obs_count), 64'(4));
    accepted = 1'b0;
    for (int i = 0; i < 10 && !accepted; i++) begin
      cycle(1'b0, 1'b1, 32'h200, 32'h0, 1'b0, 1'b0, 1'b0);
      accepted = obs_ready;
    end
    check("held_accepted", 64'(accepted), 64'(1));
    repeat (6) idle(1'b0);

    // Steady push+pop at occupancy 2 across pointer wrap
    push_one(32'h400, 1'b1);
    push_one(32'h404, 1'b1);
    for (int i = 0; i < 10; i++) begin
      push_one(PC_WIDTH'(32'h408 + 4 * i), 1'b0);
      check("steady_count", 64'(obs_count), 64'(2));
    end
    repeat (4) idle(1'b0);

    // Flush with concurrent push
    for (int i = 0; i < 3; i++) push_one(PC_WIDTH'(32'h500 + 4 * i), 1'b1);
    cycle(1'b0, 1'b1, 32'h5FC, 32'h13, 1'b1, 1'b0, 1'b1);
    check("flush_valid", 64'(obs_valid), 64'(0));
    check("flush_pc",    64'(obs_pc),    64'(0));
    idle(1'b0);
    check("post_flush_count", 64'(obs_count), 64'(0));
    check("post_flush_valid", 64'(obs_valid), 64'(0));

    // Register address extraction for add x5,x6,x10
    cycle(1'b0, 1'b1, 32'h600, 32'h00A302B3, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    check("rs1_add", 64'(obs_rs1), 64'(6));
    check("rs2_add", 64'(obs_rs2), 64'(10));
    check("rd_add",  64'(obs_rd),  64'(5));
    idle(1'b0);
    idle(1'b0);
    check("rs1_empty", 64'(obs_rs1), 64'(0));
    check("rs2_empty", 64'(obs_rs2), 64'(0));
    check("rd_empty",  64'(obs_rd),  64'(0));

`ifdef DECODE_INST_QUEUE_BYPASS_EN
    // Same-cycle bypass on an empty queue
    push_one(32'h300, 1'b0);
    check("byp_valid", 64'(obs_valid), 64'(1));
    check("byp_pc",    64'(obs_pc),    64'h300);
    idle(1'b0);
    check("byp_count", 64'(obs_count), 64'(0));
    push_one(32'h300, 1'b1);
    idle(1'b1);
    check("byp_stall_count", 64'(obs_count), 64'(1));
    idle(1'b0);
`endif

    // Randomized traffic including flushes and occasional mid-run resets
    for (int i = 0; i < 3000; i++) begin
      cycle(1'b0 + ($urandom_range(0, 199) == 0),
            ($urandom_range(0, 9) < 7),
            PC_WIDTH'($urandom), INST_WIDTH'($urandom), BP_WIDTH'($urandom_range(0, 1)),
            ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 29) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
